// File: rtl/uart_mmio_pkg.sv
// Shared constants for the console UART register window: base address,
// register offsets, LSR bit positions and the "no character" reply code.
package uart_mmio_pkg;

  localparam logic [63:0] UART_BASE    = 64'h0000_0000_1000_0000;
  localparam logic [2:0]  UART_OFF_THR = 3'd0;
  localparam logic [2:0]  UART_OFF_LSR = 3'd5;
  localparam logic [7:0]  UART_RX_NONE = 8'hFF;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  typedef struct packed {
    logic temt;
    logic thre;
    logic oe;
    logic dr;
  } lsr_bits_t;

  function automatic logic [7:0] lsr_pack(input lsr_bits_t b);
    logic [7:0] v;
    v           = 8'h00;
    v[LSR_DR]   = b.dr;
    v[LSR_OE]   = b.oe;
    v[LSR_THRE] = b.thre;
    v[LSR_TEMT] = b.temt;
    return v;
  endfunction

endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// Single-clock FIFO with a combinational head. A push while full is only
// taken when a pop frees the slot in the same cycle.
module uart_mmio_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only consumed while count > 0.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped console UART: THR stores feed a paced TX FIFO towards
// uart_out; uart_in is polled into a one-byte RBR with 16550-style LSR.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = UART_BASE,
  parameter int          TX_DEPTH  = 8,
  parameter int          TX_GAP    = 4,
  parameter int          RX_POLL   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [63:0] data_addr,
  input  logic [63:0] write_data,
  output logic        hit,
  output logic [63:0] read_data,
  output logic        io_uart_out_valid,
  output logic [7:0]  io_uart_out_ch,
  output logic        io_uart_in_valid,
  input  logic [7:0]  io_uart_in_ch
);

  // mem_read/mem_write are single-cycle strobes with no ready: any access
  // qualified by hit completes in the cycle it is presented. The uart_out
  // and uart_in strobes are likewise one-cycle pulses the simulator must take.

  localparam int CNT_W  = $clog2(TX_DEPTH) + 1;
  localparam int GAP_W  = (TX_GAP  > 1) ? $clog2(TX_GAP)  : 1;
  localparam int POLL_W = (RX_POLL > 1) ? $clog2(RX_POLL) : 1;
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(TX_GAP - 1);
  localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(RX_POLL - 1);

  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic [7:0]        rx_hold_q, rx_hold_d;
  logic              dr_q, dr_d;
  logic              oe_q, oe_d;

  logic [2:0]        off;
  logic              thr_wr, rbr_rd, lsr_rd;
  logic              gap_sat, tx_pop, tx_drop;
  logic              poll_fire, rx_got;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_dout;
  logic [CNT_W-1:0]  tx_count_unused;
  logic              unused_wdata;
  logic [7:0]        lsr;

  assign off          = data_addr[2:0];
  assign hit          = (data_addr[63:3] == BASE_ADDR[63:3]);
  assign unused_wdata = ^write_data[63:8];

  uart_mmio_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (thr_wr),
    .pop   (tx_pop),
    .din   (write_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (tx_count_unused)
  );

  always_comb begin
    thr_wr  = mem_write && hit && (off == UART_OFF_THR);
    rbr_rd  = mem_read  && hit && (off == UART_OFF_THR);
    lsr_rd  = mem_read  && hit && (off == UART_OFF_LSR);
    gap_sat = (gap_q == GAP_MAX);
    // Gating with rst keeps the reset cycle silent even with bytes queued.
    tx_pop  = !rst && !fifo_empty && gap_sat;
    tx_drop = thr_wr && fifo_full && !tx_pop;

    gap_d = gap_q;
    if (tx_pop)        gap_d = '0;
    else if (!gap_sat) gap_d = gap_q + GAP_W'(1);

    poll_fire = !rst && !dr_q && (poll_q == POLL_MAX);
    rx_got    = poll_fire && (io_uart_in_ch != UART_RX_NONE);
    if (dr_q || poll_fire) poll_d = '0;
    else                   poll_d = poll_q + POLL_W'(1);

    rx_hold_d = rx_got ? io_uart_in_ch : rx_hold_q;
    // A fresh byte outranks a clearing read so it is never lost.
    if (rx_got)      dr_d = 1'b1;
    else if (rbr_rd) dr_d = 1'b0;
    else             dr_d = dr_q;

    if (tx_drop)     oe_d = 1'b1;
    else if (lsr_rd) oe_d = 1'b0;
    else             oe_d = oe_q;
  end

  always_comb begin
    lsr = lsr_pack('{temt: fifo_empty, thre: !fifo_full, oe: oe_q, dr: dr_q});
    read_data = '0;
    if (hit) begin
      case (off)
        UART_OFF_THR: read_data = {56'b0, (dr_q ? rx_hold_q : 8'h00)};
        UART_OFF_LSR: read_data = {56'b0, lsr};
        default:      read_data = '0;
      endcase
    end
  end

  assign io_uart_out_valid = tx_pop;
  assign io_uart_out_ch    = tx_pop ? fifo_dout : 8'h00;
  assign io_uart_in_valid  = poll_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q     <= GAP_MAX;
      poll_q    <= '0;
      rx_hold_q <= '0;
      dr_q      <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      gap_q     <= gap_d;
      poll_q    <= poll_d;
      rx_hold_q <= rx_hold_d;
      dr_q      <= dr_d;
      oe_q      <= oe_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: TX characters go through an expected queue
// checked at each uart_out pulse; register loads are checked in line.
module tb_uart_mmio;

  localparam logic [63:0] THR_A = 64'h0000_0000_1000_0000;
  localparam logic [63:0] LSR_A = 64'h0000_0000_1000_0005;

  logic        clk;
  logic        rst;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] data_addr;
  logic [63:0] write_data;
  logic        hit;
  logic [63:0] read_data;
  logic        io_uart_out_valid;
  logic [7:0]  io_uart_out_ch;
  logic        io_uart_in_valid;
  logic [7:0]  io_uart_in_ch;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_st_cyc = 0;
  int last_ld_cyc = 0;
  logic [7:0] exp_q[$];
  int tx_cyc[$];
  int poll_cyc[$];
  logic [7:0] exp_ch;

  uart_mmio dut (
    .clk               (clk),
    .rst               (rst),
    .mem_write         (mem_write),
    .mem_read          (mem_read),
    .data_addr         (data_addr),
    .write_data        (write_data),
    .hit               (hit),
    .read_data         (read_data),
    .io_uart_out_valid (io_uart_out_valid),
    .io_uart_out_ch    (io_uart_out_ch),
    .io_uart_in_valid  (io_uart_in_valid),
    .io_uart_in_ch     (io_uart_in_ch)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change at negedge, cleared just after the sampling edge.
  task automatic store(input logic [63:0] addr, input logic [7:0] ch, input bit expect_tx);
    @(negedge clk);
    mem_write  = 1'b1;
    data_addr  = addr;
    write_data = {56'hDEAD_BEEF_CAFE_00, ch};
    last_st_cyc = cyc;
    if (expect_tx) exp_q.push_back(ch);
    @(posedge clk);
    #1 mem_write = 1'b0;
  endtask

  task automatic load(input logic [63:0] addr, output logic [63:0] data, output logic h);
    @(negedge clk);
    mem_read  = 1'b1;
    data_addr = addr;
    last_ld_cyc = cyc;
    #1;
    data = read_data;
    h    = hit;
    @(posedge clk);
    #1 mem_read = 1'b0;
  endtask

  // Scoreboard / monitor on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      assert (io_uart_out_valid === 1'b0 && io_uart_in_valid === 1'b0) else begin
        errors++;
        $error("FAIL reset_quiet: out_valid=%b in_valid=%b expected 0 0",
               io_uart_out_valid, io_uart_in_valid);
      end
    end else begin
      if (io_uart_out_valid === 1'b1) begin
        pulse_cnt++;
        tx_cyc.push_back(cyc);
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL tx_unexpected: got ch %h expected no pulse", io_uart_out_ch);
        end
        if (exp_q.size() != 0) begin
          exp_ch = exp_q.pop_front();
          checks++;
          assert (io_uart_out_ch === exp_ch) else begin
            errors++;
            $error("FAIL tx_char: got %h expected %h", io_uart_out_ch, exp_ch);
          end
        end
      end
      if (io_uart_in_valid === 1'b1) poll_cyc.push_back(cyc);
    end
  end

  initial begin
    logic [63:0] rd;
    logic        h;
    int          first_cyc;
    int          n;
    int          rbr_cyc;

    rst = 1'b1;
    mem_write = 1'b0;
    mem_read = 1'b0;
    data_addr = '0;
    write_data = '0;
    io_uart_in_ch = 8'hFF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    load(LSR_A, rd, h);
    check("lsr_after_reset", rd, 64'h60);
    check("hit_lsr", {63'b0, h}, 64'd1);
    load(THR_A, rd, h);
    check("rbr_empty", rd, 64'h0);

    // Two characters, paced TX_GAP apart, first one the cycle after the store
    tx_cyc.delete();
    store(THR_A, 8'h48, 1'b1);
    first_cyc = last_st_cyc;
    store(THR_A, 8'h69, 1'b1);
    repeat (12) @(posedge clk);
    check("tx_pulse_count", 64'(tx_cyc.size()), 64'd2);
    if (tx_cyc.size() >= 2) begin
      check("tx_first_latency", 64'(tx_cyc[0] - first_cyc), 64'd1);
      check("tx_gap", 64'(tx_cyc[1] - tx_cyc[0]), 64'd4);
    end
    load(LSR_A, rd, h);
    check("lsr_temt", rd, 64'h60);

    // Fill: drain pops at stores 2, 6, 10, so the 11th store fills and the 12th drops
    for (int i = 0; i < 11; i++) store(THR_A, 8'h30 + 8'(i), 1'b1);
    store(THR_A, 8'h3B, 1'b0);
    load(LSR_A, rd, h);
    check("lsr_full_oe", rd, 64'h02);
    load(LSR_A, rd, h);
    check("lsr_oe_cleared", rd, 64'h00);
    repeat (40) @(posedge clk);
    check("drain1_empty", 64'(exp_q.size()), 64'd0);
    load(LSR_A, rd, h);
    check("lsr_after_drain1", rd, 64'h60);

    // Fill again, then push into the full FIFO on the cycle it pops
    for (int i = 0; i < 11; i++) store(THR_A, 8'h40 + 8'(i), 1'b1);
    repeat (2) @(posedge clk);
    store(THR_A, 8'h4B, 1'b1);
    load(LSR_A, rd, h);
    check("lsr_full_no_oe", rd, 64'h00);
    repeat (45) @(posedge clk);
    check("drain2_empty", 64'(exp_q.size()), 64'd0);
    load(LSR_A, rd, h);
    check("lsr_after_drain2", rd, 64'h60);

    // RX polling with "no character" replies
    poll_cyc.delete();
    for (int i = 0; i < 50 && poll_cyc.size() < 2; i++) @(posedge clk);
    check("poll_seen_two", {63'b0, poll_cyc.size() >= 2}, 64'd1);
    if (poll_cyc.size() >= 2) check("poll_period", 64'(poll_cyc[1] - poll_cyc[0]), 64'd16);
    #1 io_uart_in_ch = 8'h41;
    poll_cyc.delete();
    for (int i = 0; i < 20 && poll_cyc.size() < 1; i++) @(posedge clk);
    check("poll_with_char", 64'(poll_cyc.size()), 64'd1);
    #1 io_uart_in_ch = 8'hFF;
    n = poll_cyc.size();
    repeat (40) @(posedge clk);
    check("no_poll_while_dr", 64'(poll_cyc.size()), 64'(n));
    load(LSR_A, rd, h);
    check("lsr_dr", rd, 64'h61);
    load(THR_A, rd, h);
    rbr_cyc = last_ld_cyc;
    check("rbr_data", rd, 64'h41);
    load(LSR_A, rd, h);
    check("lsr_dr_cleared", rd, 64'h60);
    poll_cyc.delete();
    for (int i = 0; i < 30 && poll_cyc.size() < 1; i++) @(posedge clk);
    check("poll_after_rbr_seen", 64'(poll_cyc.size()), 64'd1);
    if (poll_cyc.size() >= 1) check("poll_after_rbr_delay", 64'(poll_cyc[0] - rbr_cyc), 64'd16);
    load(THR_A, rd, h);
    check("rbr_after_clear", rd, 64'h0);

    // Reset with bytes queued: the first byte has left, the rest are discarded
    for (int i = 0; i < 5; i++) store(THR_A, 8'h50 + 8'(i), 1'b1);
    rst = 1'b1;
    check("pre_reset_remaining", 64'(exp_q.size()), 64'd4);
    exp_q.delete();
    pulse_cnt = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    check("no_tx_after_reset", 64'(pulse_cnt), 64'd0);
    load(LSR_A, rd, h);
    check("lsr_after_mid_reset", rd, 64'h60);
    load(64'h0000_0000_1000_0003, rd, h);
    check("unmapped_off3", rd, 64'h0);
    load(64'h0000_0000_1000_0008, rd, h);
    check("hit_outside", {63'b0, h}, 64'd0);
    check("read_outside", rd, 64'h0);

    // A store to the LSR offset is ignored
    store(LSR_A, 8'hAA, 1'b0);
    repeat (10) @(posedge clk);
    check("lsr_store_ignored", 64'(pulse_cnt), 64'd0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
